// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and byte/word helpers for the AES-128 key schedule
package aes_pkg;
  typedef enum logic [1:0] {IDLE, EMIT, SUB} state_e;
  localparam int AES_NR = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  typedef logic [0:3][31:0] key_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: key intake, shared S-box and round-key stream handshakes
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;
  logic        key_valid_i;
  logic        key_ready_o;
  key_t        key_i;
  logic        sbox_req_o;
  logic [31:0] sbox_word_o;
  logic        sbox_ack_i;
  logic [31:0] sbox_word_i;
  logic        rk_valid_o;
  logic        rk_ready_i;
  key_t        rk_o;
  logic [3:0]  rk_idx_o;
  modport master (
    input  key_valid_i, key_i, sbox_ack_i, sbox_word_i, rk_ready_i,
    output key_ready_o, sbox_req_o, sbox_word_o, rk_valid_o, rk_o, rk_idx_o
  );
  modport slave (
    output key_valid_i, key_i, sbox_ack_i, sbox_word_i, rk_ready_i,
    input  key_ready_o, sbox_req_o, sbox_word_o, rk_valid_o, rk_o, rk_idx_o
  );
endinterface

// File: rtl/aes_key_expand_step.sv
// aes_key_expand_step: one AES-128 expansion round from SubWord result and Rcon
module aes_key_expand_step
  import aes_pkg::*;
(
  input  key_t        key_i,
  input  logic [31:0] sub_i,
  input  logic [7:0]  rcon_i,
  output key_t        key_o
);
  logic [31:0] t, w0, w1, w2, w3;
  always_comb begin
    t  = sub_i ^ {rcon_i, 24'h0};
    w0 = key_i[0] ^ t;
    w1 = key_i[1] ^ w0;
    w2 = key_i[2] ^ w1;
    w3 = key_i[3] ^ w2;
  end
  assign key_o = {w0, w1, w2, w3};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: walks AES-128 key expansion, borrowing the S-box and streaming round keys
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int         NUM_ROUNDS = AES_NR,
  parameter logic [7:0] RCON_INIT  = AES_RCON_INIT
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        abort_i,
  aes_key_sched_ctrl_if.master        bus,
  output logic                        busy_o,
  output logic                        done_o
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  state_e     state_q, state_d;
  key_t       key_q, key_d, next_key;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;
  logic       key_ready_q, key_ready_d;
  logic       rk_valid_q, rk_valid_d;
  logic       sbox_req_q, sbox_req_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  aes_key_expand_step u_step (
    .key_i  (key_q),
    .sub_i  (bus.sbox_word_i),
    .rcon_i (rcon_q),
    .key_o  (next_key)
  );
  // abort outranks every transition; the key register is deliberately kept on abort
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE && bus.key_valid_i) begin
      state_d = EMIT;
      key_d   = bus.key_i;
      idx_d   = 4'd0;
      rcon_d  = RCON_INIT;
    end else if (state_q == EMIT && bus.rk_ready_i) begin
      state_d = (idx_q == LAST) ? IDLE : SUB;
      done_d  = (idx_q == LAST);
    end else if (state_q == SUB && bus.sbox_ack_i) begin
      state_d = EMIT;
      key_d   = next_key;
      idx_d   = idx_q + 4'd1;
      rcon_d  = xtime(rcon_q);
    end
    key_ready_d = (state_d == IDLE);
    rk_valid_d  = (state_d == EMIT);
    sbox_req_d  = (state_d == SUB);
    busy_d      = (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      idx_q       <= 4'd0;
      rcon_q      <= RCON_INIT;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      sbox_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      rcon_q      <= rcon_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      sbox_req_q  <= sbox_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign bus.key_ready_o = key_ready_q;
  assign bus.rk_valid_o  = rk_valid_q;
  assign bus.rk_o        = key_q;
  assign bus.rk_idx_o    = idx_q;
  assign bus.sbox_req_o  = sbox_req_q;
  assign bus.sbox_word_o = rot_word(key_q[3]);
  assign busy_o          = busy_q;
  assign done_o          = done_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: scoreboard bench with a GF(2^8) S-box model and reference key expansion
module tb_aes_key_sched_ctrl;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ALT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;
  logic clk = 1'b0, nrst = 1'b0, abort_i = 1'b0;
  logic busy_o, done_o;
  aes_key_sched_ctrl_if bus ();
  aes_key_sched_ctrl dut (
    .clk(clk), .nrst(nrst), .abort_i(abort_i), .bus(bus), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic [7:0] sbox_tbl [256];
  logic [127:0] model_rk [11];
  logic [127:0] rk_seen [11];
  int rk_cyc [11];
  int ready_pct = 100, ack_max = 0, wait_cnt = 0, done_cnt = 0, accept_cyc = 0;
  logic ack_block = 1'b0, sbox_zero = 1'b0, first_pend = 1'b0;
  logic [3:0] stall_idx = 4'hf;
  logic [31:0] first_sb = 32'h0;
  logic pv = 1'b0, phs = 1'b0, sp = 1'b0, sa = 1'b0;
  logic [127:0] prk = '0;
  logic [3:0] pidx = '0;
  logic [31:0] sw = '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
  endfunction

  task automatic push_schedule(input logic [127:0] k, input logic zero);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    exp_t e;
    rc = 8'h01;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = (zero ? 32'h0 : subw({t[23:0], t[31:24]})) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      e.idx = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      model_rk[r] = e.key;
      exp_q.push_back(e);
    end
  endtask

  // consumer, S-box responder and stability monitor; all sampling on the falling edge
  initial begin
    exp_t e;
    bus.rk_ready_i = 1'b0; bus.sbox_ack_i = 1'b0; bus.sbox_word_i = 32'h0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        pv = 1'b0; phs = 1'b0; sp = 1'b0; sa = 1'b0;
        bus.rk_ready_i = 1'b0; bus.sbox_ack_i = 1'b0;
      end else begin
        if (done_o) done_cnt++;
        if (pv && !phs && bus.rk_valid_o) begin
          checks++;
          if (bus.rk_o !== prk || bus.rk_idx_o !== pidx) begin
            errors++;
            $display("FAIL rk_stall_stable got %0d:%h want %0d:%h", bus.rk_idx_o, bus.rk_o, pidx, prk);
          end
        end
        bus.rk_ready_i = !(bus.rk_valid_o && bus.rk_idx_o == stall_idx) && ($urandom_range(0, 99) < ready_pct);
        phs = bus.rk_valid_o && bus.rk_ready_i;
        if (phs) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rk_unexpected got %0d:%h want none", bus.rk_idx_o, bus.rk_o);
          end else begin
            e = exp_q.pop_front();
            if (bus.rk_idx_o !== e.idx || bus.rk_o !== e.key) begin
              errors++;
              $display("FAIL rk_scoreboard got %0d:%h want %0d:%h", bus.rk_idx_o, bus.rk_o, e.idx, e.key);
            end
          end
          if (bus.rk_idx_o <= 4'd10) begin
            rk_seen[bus.rk_idx_o] = bus.rk_o;
            rk_cyc[bus.rk_idx_o] = cyc;
          end
        end
        pv = bus.rk_valid_o; prk = bus.rk_o; pidx = bus.rk_idx_o;
        if (sp && !sa && bus.sbox_req_o) begin
          checks++;
          if (bus.sbox_word_o !== sw) begin
            errors++;
            $display("FAIL sbox_word_stable got %h want %h", bus.sbox_word_o, sw);
          end
        end
        if (bus.sbox_req_o && first_pend) begin
          first_sb = bus.sbox_word_o;
          first_pend = 1'b0;
        end
        sa = 1'b0;
        if (bus.sbox_req_o && !ack_block) begin
          if (wait_cnt == 0) begin
            sa = 1'b1;
            wait_cnt = int'($urandom_range(0, ack_max));
          end else wait_cnt--;
        end
        bus.sbox_ack_i = sa;
        bus.sbox_word_i = (sa && !sbox_zero) ? subw(bus.sbox_word_o) : 32'h0;
        sp = bus.sbox_req_o; sw = bus.sbox_word_o;
      end
    end
  end

  task automatic send_key(input logic [127:0] k, input logic zero);
    bus.key_i = k;
    bus.key_valid_i = 1'b1;
    for (int i = 0; i < 50 && bus.key_ready_o !== 1'b1; i++) @(negedge clk);
    checks++;
    if (bus.key_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL key_accept_timeout got ready=%b want 1", bus.key_ready_o);
    end else begin
      accept_cyc = cyc;
      push_schedule(k, zero);
    end
    @(negedge clk);
    bus.key_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done_o === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (dc < 0) begin
      errors++;
      $display("FAIL done_timeout got none want done_o within 2000 cycles");
    end
  endtask

  task automatic wait_rk(input logic [3:0] idx, input logic want_req);
    int i;
    for (i = 0; i < 500; i++) begin
      if (bus.rk_idx_o == idx && (want_req ? bus.sbox_req_o : bus.rk_valid_o)) break;
      @(negedge clk);
    end
    checks++;
    if (i == 500) begin
      errors++;
      $display("FAIL wait_rk_timeout got idx=%0d want idx=%0d req=%b", bus.rk_idx_o, idx, want_req);
    end
  endtask

  task automatic run_fips(input int rp, input int am, input logic timing);
    int dc;
    ready_pct = rp; ack_max = am; wait_cnt = 0; sbox_zero = 1'b0; first_pend = 1'b1;
    for (int i = 0; i < 11; i++) begin rk_seen[i] = '0; rk_cyc[i] = -1; end
    send_key(FIPS_KEY, 1'b0);
    wait_done(dc);
    checks++;
    if (bus.key_ready_o !== 1'b1) begin errors++; $display("FAIL fips_ready_at_done got %b want 1", bus.key_ready_o); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fips_missing_keys got %0d left want 0", exp_q.size()); end
    checks++;
    if (rk_seen[0] !== FIPS_KEY) begin errors++; $display("FAIL fips_rk0 got %h want %h", rk_seen[0], FIPS_KEY); end
    checks++;
    if (first_sb !== 32'hcf4f3c09) begin errors++; $display("FAIL fips_first_sbox got %h want cf4f3c09", first_sb); end
    checks++;
    if (rk_seen[1] !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1 got %h want %h", rk_seen[1], FIPS_RK1); end
    checks++;
    if (rk_seen[10] !== FIPS_RK10) begin errors++; $display("FAIL fips_rk10 got %h want %h", rk_seen[10], FIPS_RK10); end
    if (timing) begin
      checks++;
      if (rk_cyc[0] != accept_cyc + 1) begin errors++; $display("FAIL lat_rk0 got %0d want %0d", rk_cyc[0] - accept_cyc, 1); end
      checks++;
      if (rk_cyc[10] != accept_cyc + 21) begin errors++; $display("FAIL lat_rk10 got %0d want %0d", rk_cyc[10] - accept_cyc, 21); end
      checks++;
      if (dc != accept_cyc + 22) begin errors++; $display("FAIL lat_done got %0d want %0d", dc - accept_cyc, 22); end
    end
    @(negedge clk);
    ready_pct = 100; ack_max = 0; wait_cnt = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.key_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b busy=%b done=%b want 1 0 0", bus.key_ready_o, busy_o, done_o);
    end
    checks++;
    if (bus.rk_valid_o !== 1'b0 || bus.sbox_req_o !== 1'b0 || bus.rk_idx_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_hs got valid=%b req=%b idx=%0d want 0 0 0", bus.rk_valid_o, bus.sbox_req_o, bus.rk_idx_o);
    end
    checks++;
    if (bus.rk_o !== 128'h0 || bus.sbox_word_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got rk=%h sbw=%h want 0 0", bus.rk_o, bus.sbox_word_o);
    end
  endtask

  task automatic test_fips();
    run_fips(100, 0, 1'b1);
  endtask

  task automatic test_rcon();
    int dc;
    logic [7:0] rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    sbox_zero = 1'b1;
    for (int i = 0; i < 11; i++) rk_seen[i] = '1;
    send_key(128'h0, 1'b1);
    wait_done(dc);
    // with a zero S-box each round's w0 top byte differs from the last by exactly Rcon
    for (int n = 1; n < 11; n++) begin
      checks++;
      if ((rk_seen[n][127:120] ^ rk_seen[n-1][127:120]) !== rc_exp[n-1]) begin
        errors++;
        $display("FAIL rcon_round%0d got %h want %h", n, rk_seen[n][127:120] ^ rk_seen[n-1][127:120], rc_exp[n-1]);
      end
    end
    checks++;
    if (bus.rk_idx_o !== 4'd10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rcon_idx_end got idx=%0d left=%0d want 10 0", bus.rk_idx_o, exp_q.size());
    end
    sbox_zero = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    run_fips(55, 5, 1'b0);
    run_fips(30, 3, 1'b0);
  endtask

  task automatic test_busy_reject();
    int dc;
    send_key(FIPS_KEY, 1'b0);
    wait_rk(4'd4, 1'b0);
    bus.key_i = ALT_KEY;
    bus.key_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.key_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL busy_reject got ready=%b busy=%b want 0 1", bus.key_ready_o, busy_o);
      end
      @(negedge clk);
    end
    bus.key_valid_i = 1'b0;
    wait_done(dc);
    checks++;
    if (rk_seen[10] !== FIPS_RK10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_final got %h left=%0d want %h 0", rk_seen[10], exp_q.size(), FIPS_RK10);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int dc, dn;
    send_key(FIPS_KEY, 1'b0);
    wait_rk(4'd5, 1'b0);
    ack_block = 1'b1;
    @(negedge clk);
    wait_rk(4'd5, 1'b1);
    abort_i = 1'b1;
    dn = done_cnt;
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if (bus.sbox_req_o !== 1'b0 || bus.rk_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got req=%b valid=%b busy=%b done=%b want 0 0 0 0", bus.sbox_req_o, bus.rk_valid_o, busy_o, done_o);
    end
    checks++;
    if (bus.key_ready_o !== 1'b1 || bus.rk_o !== model_rk[5]) begin
      errors++;
      $display("FAIL abort_retain got ready=%b rk=%h want 1 %h", bus.key_ready_o, bus.rk_o, model_rk[5]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != dn) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt - dn); end
    exp_q.delete();
    ack_block = 1'b0;
    wait_cnt = 0;
    send_key(ALT_KEY, 1'b0);
    wait_done(dc);
    checks++;
    if (rk_seen[1] !== model_rk[1] || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_fresh_rk1 got %h left=%0d want %h 0", rk_seen[1], exp_q.size(), model_rk[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_idle();
    abort_i = 1'b1;
    bus.key_i = FIPS_KEY;
    bus.key_valid_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    bus.key_valid_i = 1'b0;
    checks++;
    if (bus.key_ready_o !== 1'b1 || busy_o !== 1'b0 || bus.rk_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_state got ready=%b busy=%b valid=%b want 1 0 0", bus.key_ready_o, busy_o, bus.rk_valid_o);
    end
    checks++;
    if (bus.rk_o !== model_rk[10]) begin
      errors++;
      $display("FAIL abort_idle_noload got %h want %h", bus.rk_o, model_rk[10]);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    stall_idx = 4'd3;
    send_key(FIPS_KEY, 1'b0);
    wait_rk(4'd3, 1'b0);
    repeat (3) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (bus.rk_valid_o !== 1'b0 || bus.sbox_req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || bus.key_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_ctrl got valid=%b req=%b busy=%b done=%b ready=%b want 0 0 0 0 1",
               bus.rk_valid_o, bus.sbox_req_o, busy_o, done_o, bus.key_ready_o);
    end
    checks++;
    if (bus.rk_idx_o !== 4'd0 || bus.rk_o !== 128'h0 || bus.sbox_word_o !== 32'h0) begin
      errors++;
      $display("FAIL areset_data got idx=%0d rk=%h sbw=%h want 0 0 0", bus.rk_idx_o, bus.rk_o, bus.sbox_word_o);
    end
    exp_q.delete();
    stall_idx = 4'hf;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.key_ready_o !== 1'b1) begin errors++; $display("FAIL areset_release_ready got %b want 1", bus.key_ready_o); end
    run_fips(100, 0, 1'b1);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_tbl[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    bus.key_valid_i = 1'b0;
    bus.key_i = '0;
    repeat (3) @(negedge clk);
    test_reset();
    nrst = 1'b1;
    @(negedge clk);
    test_reset();
    test_fips();
    test_rcon();
    test_backpressure();
    test_busy_reject();
    test_abort();
    test_abort_idle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
